// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader and the memory it fills.
package imem_loader_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  function automatic int imem_depth(input int addr_w);
    return 2 ** addr_w;
  endfunction

  localparam int IMEM_DEPTH = imem_depth(ADDR_W_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR,
    S_CHECK
  } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles accepted bytes MSB-first into DATA_W-bit words; word_ready marks the
// accept that completes a word, with word carrying the finished value that cycle.
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        in_byte,
  output logic [DATA_W-1:0] word,
  output logic              word_ready
);

  localparam int BPW   = DATA_W / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W+7:0] shift_ext;

  // Earlier bytes move toward the MSB as each new byte enters at the bottom.
  assign shift_ext  = {shift_q, in_byte};
  assign word       = shift_ext[DATA_W-1:0];
  assign word_ready = accept && (cnt_q == CNT_W'(BPW - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      shift_q <= word;
      cnt_q   <= word_ready ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory; holds the core until the program is in.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before release.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  localparam int          DEPTH   = imem_depth(ADDR_W);
  localparam int          CNT_W   = ADDR_W + 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  target_q, words_q, words_inc, hdr_target;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              transfer, start_ok, hdr_bad, accept;
  logic [DATA_W-1:0] word;
  logic              word_ready;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        xor_q;
`endif

  assign in_ready = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign transfer = in_valid && in_ready;
  assign accept   = transfer && (state_q == S_DATA);
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));

  // A count byte of zero stands for a completely full memory.
  assign hdr_bad    = 32'(in_byte) > DEPTH_U;
  assign hdr_target = (in_byte == 8'd0) ? CNT_W'(DEPTH) : CNT_W'(in_byte);
  assign words_inc  = words_q + 1'b1;

  imem_word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .accept     (accept),
    .in_byte    (in_byte),
    .word       (word),
    .word_ready (word_ready)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_COUNT;
      S_COUNT:               if (transfer) state_d = hdr_bad ? S_ERR : S_DATA;
      S_DATA:                if (word_ready) state_d = S_WRITE;
      S_WRITE: begin
        if (words_inc == target_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:               if (transfer) state_d = (in_byte == xor_q) ? S_DONE : S_ERR;
`endif
      default:               state_d = S_IDLE;
    endcase
  end

  // The write port is latched on the completing byte so it holds between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      target_q  <= '0;
      words_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        addr_q   <= '0;
        words_q  <= '0;
        target_q <= '0;
`ifdef LOADER_CHECKSUM_EN
        xor_q    <= '0;
`endif
      end
      if ((state_q == S_COUNT) && transfer) target_q <= hdr_target;
      if (word_ready) begin
        wr_addr_q <= addr_q;
        wr_data_q <= word;
      end
      if (state_q == S_WRITE) begin
        addr_q  <= addr_q + 1'b1;
        words_q <= words_inc;
      end
`ifdef LOADER_CHECKSUM_EN
      if (accept) xor_q <= xor_q ^ in_byte;
`endif
    end
  end

  assign wr_en     = (state_q == S_WRITE);
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign core_hold = (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives byte streams, models the instruction memory,
// and checks write strobes, handshake and status outputs against hand-computed values.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        core_hold;
  logic        done;
  logic        err;

  logic [31:0] mem [0:63];
  logic [31:0] prog [0:63];
  int          wr_count = 0;
  int          last_addr = -1;
  int          n_checks = 0;
  int          n_fail = 0;

  imem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .core_hold (core_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory model plus a record of every write strobe.
  always @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
      wr_count     <= wr_count + 1;
      last_addr    <= int'(wr_addr);
    end
  end

  always @(negedge clk) begin
    if (wr_en) checkOutput("ready_in_write", {31'd0, in_ready}, 32'd0);
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit stall);
    bit accepted = 1'b0;
    int waited = 0;
    if (stall) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_byte  = b;
    while (!accepted && waited < 20) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk); #1;
      waited++;
    end
    if (!accepted) checkOutput("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_program(input logic [7:0] count_byte, input int nwords, input bit stall);
    logic [7:0] xsum = 8'h00;
    logic [7:0] b;
    pulse_start();
    checkOutput("count_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(count_byte, stall);
    for (int w = 0; w < nwords; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = prog[w][31 - 8*k -: 8];
        xsum ^= b;
        applyStimulus(b, stall);
      end
      checkOutput("wr_en_after_4th", {31'd0, wr_en}, 32'd1);
      checkOutput("wr_addr", {26'd0, wr_addr}, w);
      checkOutput("wr_data", wr_data, prog[w]);
    end
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(xsum, stall);
    in_valid = 1'b0;
`else
    in_valid = 1'b0;
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("rst_core_hold", {31'd0, core_hold}, 32'd1);
    checkOutput("rst_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
    checkOutput("rst_wr_data", wr_data, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("idle_core_hold", {31'd0, core_hold}, 32'd1);
    checkOutput("idle_done", {31'd0, done}, 32'd0);
    checkOutput("idle_writes", wr_count, 32'd0);

    $display("[TB] two-word load");
    prog[0] = 32'hDEADBEEF;
    prog[1] = 32'h12345678;
    load_program(8'h02, 2, 1'b0);
    checkOutput("two_done", {31'd0, done}, 32'd1);
    checkOutput("two_core_hold", {31'd0, core_hold}, 32'd0);
    checkOutput("two_wr_en_idle", {31'd0, wr_en}, 32'd0);
    checkOutput("two_wr_data_hold", wr_data, 32'h12345678);
    checkOutput("two_writes", wr_count, 32'd2);
    checkOutput("mem0", mem[0], 32'hDEADBEEF);
    checkOutput("mem1", mem[1], 32'h12345678);

    $display("[TB] stalled load");
    prog[0] = 32'hAABBCCDD;
    prog[1] = 32'h01020304;
    prog[2] = 32'hF0E1D2C3;
    base = wr_count;
    load_program(8'h03, 3, 1'b1);
    checkOutput("stall_done", {31'd0, done}, 32'd1);
    checkOutput("stall_writes", wr_count - base, 32'd3);
    checkOutput("stall_mem0", mem[0], 32'hAABBCCDD);
    checkOutput("stall_mem1", mem[1], 32'h01020304);
    checkOutput("stall_mem2", mem[2], 32'hF0E1D2C3);

    $display("[TB] full-depth load");
    for (int i = 0; i < 64; i++) prog[i] = {8'(i), 8'(i + 64), ~8'(i), 8'(i * 3)};
    base = wr_count;
    load_program(8'h00, 64, 1'b0);
    checkOutput("full_done", {31'd0, done}, 32'd1);
    checkOutput("full_writes", wr_count - base, 32'd64);
    checkOutput("full_last_addr", last_addr, 32'd63);
    checkOutput("full_mem0", mem[0], 32'h0040FF00);
    checkOutput("full_mem31", mem[31], 32'h1F5FE05D);
    checkOutput("full_mem63", mem[63], 32'h3F7FC0BD);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("full_no_extra_write", wr_count - base, 32'd64);

    $display("[TB] bad header");
    base = wr_count;
    pulse_start();
    checkOutput("restart_done_clr", {31'd0, done}, 32'd0);
    checkOutput("restart_hold", {31'd0, core_hold}, 32'd1);
    applyStimulus(8'h41, 1'b0);
    in_valid = 1'b0;
    checkOutput("bad_err", {31'd0, err}, 32'd1);
    checkOutput("bad_core_hold", {31'd0, core_hold}, 32'd1);
    checkOutput("bad_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bad_err_sticky", {31'd0, err}, 32'd1);
    checkOutput("bad_no_write", wr_count - base, 32'd0);

    $display("[TB] reset mid-word");
    prog[0] = 32'h11223344;
    prog[1] = 32'h55667788;
    base = wr_count;
    pulse_start();
    checkOutput("err_cleared", {31'd0, err}, 32'd0);
    applyStimulus(8'h02, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(prog[0][31 - 8*k -: 8], 1'b0);
    applyStimulus(8'h55, 1'b0);
    applyStimulus(8'h66, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("mid_rst_core_hold", {31'd0, core_hold}, 32'd1);
    checkOutput("mid_rst_wr_addr", {26'd0, wr_addr}, 32'd0);
    checkOutput("mid_rst_wr_data", wr_data, 32'd0);
    checkOutput("mid_rst_done", {31'd0, done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mid_rst_writes", wr_count - base, 32'd1);
    checkOutput("mid_rst_mem0", mem[0], 32'h11223344);
    prog[0] = 32'hCAFEF00D;
    load_program(8'h01, 1, 1'b0);
    checkOutput("reload_done", {31'd0, done}, 32'd1);
    checkOutput("reload_mem0", mem[0], 32'hCAFEF00D);

`ifdef LOADER_CHECKSUM_EN
    $display("[TB] checksum");
    pulse_start();
    applyStimulus(8'h01, 1'b0);
    for (int k = 1; k <= 4; k++) applyStimulus(8'(k), 1'b0);
    applyStimulus(8'h04, 1'b0);
    in_valid = 1'b0;
    checkOutput("cks_good_done", {31'd0, done}, 32'd1);
    checkOutput("cks_good_mem0", mem[0], 32'h01020304);
    pulse_start();
    applyStimulus(8'h01, 1'b0);
    for (int k = 1; k <= 4; k++) applyStimulus(8'(k), 1'b0);
    applyStimulus(8'h05, 1'b0);
    in_valid = 1'b0;
    checkOutput("cks_bad_err", {31'd0, err}, 32'd1);
    checkOutput("cks_bad_hold", {31'd0, core_hold}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
